// File: rtl/data_mem_ctrl.sv
// Wait-state data-memory responder for the MEM stage: a word-organised RAM behind
// an IDLE/WAIT/DONE FSM that stalls the pipeline until each access commits.
module data_mem_ctrl #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // IDLE already accounts for one stall cycle, so WAIT counts the remaining ones down to 0.
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES >= 2) ? 4'(WAIT_CYCLES - 2) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [3:0]              cnt_reg, cnt_next;
    logic [31:0]             din_reg;
    logic [31:0]             ram [0:DEPTH-1];

    logic                    req;
    logic                    misaligned;
    logic                    go;
    logic                    commit;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    unused_addr_bits;

    assign req        = mem_ren | mem_wen;
    assign misaligned = (mem_addr[1:0] != 2'b00);
    assign go         = req & ~misaligned;
    assign idx        = mem_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^mem_addr[31:ADDR_WIDTH+2];

    // The edge entering DONE is the single point where RAM and read data change.
    assign commit = ~rst & (state_reg != S_DONE) & (state_next == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (go) begin
                    if (WAIT_CYCLES == 1) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                // A dropped request means the pipeline flushed the access.
                if (!go) begin
                    state_next = S_IDLE;
                    cnt_next   = 4'd0;
                end else if (cnt_reg == 4'd0) begin
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_stall = go & ((state_reg == S_IDLE) | (state_reg == S_WAIT));
        mem_err   = (state_reg == S_IDLE) & req & (misaligned | (mem_ren & mem_wen));
    end

    // RAM array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (commit && mem_wen) begin
            ram[idx] <= mem_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_reg <= 32'd0;
        end else if (commit && mem_ren && !mem_wen) begin
            din_reg <= ram[idx];
        end
    end

    assign mem_din = din_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed plus randomized checks of data_mem_ctrl against an array-based memory model;
// two instances cover the multi-cycle (2) and single-cycle (1) wait settings.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        ren, wen;
    logic [31:0] addr, dout;

    logic        ren_a, wen_a, ren_b, wen_b;
    logic [31:0] din_a, din_b;
    logic        stall_a, stall_b, err_a, err_b;
    logic [31:0] o_din;
    logic        o_stall, o_err;

    logic [31:0] model_mem [2][1024];
    bit          model_valid [2][1024];
    logic [31:0] model_din [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign ren_a   = ren & ~sel;
    assign wen_a   = wen & ~sel;
    assign ren_b   = ren & sel;
    assign wen_b   = wen & sel;
    assign o_din   = sel ? din_b : din_a;
    assign o_stall = sel ? stall_b : stall_a;
    assign o_err   = sel ? err_b : err_a;

    data_mem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .mem_ren(ren_a), .mem_wen(wen_a),
        .mem_addr(addr), .mem_dout(dout),
        .mem_din(din_a), .mem_stall(stall_a), .mem_err(err_a)
    );

    data_mem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .mem_ren(ren_b), .mem_wen(wen_b),
        .mem_addr(addr), .mem_dout(dout),
        .mem_din(din_b), .mem_stall(stall_b), .mem_err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access: held until stall drops, then released after the DONE cycle.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        int s   = sel ? 1 : 0;
        int wc  = sel ? 1 : 2;
        int idx = int'((a >> 2) % 1024);
        ren = r; wen = w; addr = a; dout = d;
        for (int k = 0; k < wc; k++) begin
            @(negedge clk);
            chk("stall_high", 32'(o_stall), 32'd1);
            chk("err_during_stall", 32'(o_err), 32'((k == 0) && r && w));
            @(posedge clk); #1;
        end
        if (w) begin
            model_mem[s][idx]   = d;
            model_valid[s][idx] = 1'b1;
        end else if (r) begin
            model_din[s] = model_mem[s][idx];
        end
        @(negedge clk);
        chk("stall_done", 32'(o_stall), 32'd0);
        chk("err_done", 32'(o_err), 32'd0);
        chk("din_done", o_din, model_din[s]);
        @(posedge clk); #1;
        ren = 1'b0; wen = 1'b0;
        $display("[TB] dut%0d %s addr=%h data=%h din=%h", s, w ? "WR" : "RD", a, d, o_din);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        int          idx;
        logic [31:0] a, d;

        rst = 1'b1; sel = 1'b0; ren = 1'b0; wen = 1'b0; addr = 32'd0; dout = 32'd0;
        model_din[0] = 32'd0; model_din[1] = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_stall", 32'(stall_a), 32'd0);
        chk("reset_err", 32'(err_a), 32'd0);
        chk("reset_din_a", din_a, 32'd0);
        chk("reset_din_b", din_b, 32'd0);
        @(posedge clk); #1;

        // Write then read
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h10, 32'h0);

        // Misaligned read and write: no stall, no access
        ren = 1'b1; addr = 32'h13;
        @(negedge clk);
        chk("mis_rd_err", 32'(err_a), 32'd1);
        chk("mis_rd_stall", 32'(stall_a), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mis_rd_stay_idle", 32'(stall_a), 32'd0);
        chk("mis_rd_din", din_a, model_din[0]);
        @(posedge clk); #1;
        ren = 1'b0; wen = 1'b1; dout = 32'hBAD0BAD0;
        @(negedge clk);
        chk("mis_wr_err", 32'(err_a), 32'd1);
        chk("mis_wr_stall", 32'(stall_a), 32'd0);
        @(posedge clk); #1;
        wen = 1'b0;
        access(1'b1, 1'b0, 32'h10, 32'h0);

        // Flush abort of a write
        access(1'b0, 1'b1, 32'h20, 32'h55);
        wen = 1'b1; addr = 32'h20; dout = 32'h1234;
        @(negedge clk);
        chk("flush_stall", 32'(stall_a), 32'd1);
        @(posedge clk); #1;
        wen = 1'b0;
        @(negedge clk);
        chk("flush_stall_drop", 32'(stall_a), 32'd0);
        chk("flush_din", din_a, model_din[0]);
        @(posedge clk); #1;
        access(1'b1, 1'b0, 32'h20, 32'h0);

        // Reset in the middle of a read
        ren = 1'b1; addr = 32'h10;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ren = 1'b0;
        model_din[0] = 32'd0; model_din[1] = 32'd0;
        @(negedge clk);
        chk("rst_mid_stall", 32'(stall_a), 32'd0);
        chk("rst_mid_din", din_a, 32'd0);
        @(posedge clk); #1;
        access(1'b1, 1'b0, 32'h10, 32'h0);

        // Address wrap and read+write priority
        access(1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5);
        access(1'b1, 1'b0, 32'h0, 32'h0);
        access(1'b1, 1'b1, 32'h8, 32'h77);
        access(1'b1, 1'b0, 32'h8, 32'h0);

        // Random traffic, upper address bits scrambled to exercise wrap
        for (int i = 0; i < 24; i++) begin
            idx = $urandom_range(0, 15);
            a   = ($urandom() & 32'hFFFF_F000) | (idx << 2);
            d   = $urandom();
            if (model_valid[0][idx] && ($urandom_range(0, 1) == 1))
                access(1'b1, 1'b0, a, 32'h0);
            else
                access(1'b0, 1'b1, a, d);
        end

        // Single-wait instance: back-to-back reads held until stall drops
        sel = 1'b1;
        access(1'b0, 1'b1, 32'h4, 32'h11111111);
        access(1'b0, 1'b1, 32'h8, 32'h22222222);
        access(1'b0, 1'b1, 32'hC, 32'h33333333);
        access(1'b1, 1'b0, 32'h4, 32'h0);
        access(1'b1, 1'b0, 32'h8, 32'h0);
        access(1'b1, 1'b0, 32'hC, 32'h0);
        for (int i = 0; i < 10; i++) begin
            idx = $urandom_range(1, 3);
            a   = ($urandom() & 32'hFFFF_F000) | (idx << 2);
            if ($urandom_range(0, 1) == 1)
                access(1'b1, 1'b0, a, 32'h0);
            else
                access(1'b0, 1'b1, a, $urandom());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
